voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_if.sv | 29 ++
 rtl/voice_allocator.sv | 181 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// Event handshake, voice status and accumulator-configuration bus of the voice allocator.
// The allocator sits on the slave side: it consumes note events and drives everything else.
interface voice_allocator_if #(
   parameter int NUM_VOICES = 4
);
   logic                            ev_valid;
   logic                            ev_ready;
   logic                            ev_on;
   logic [7:0]                      ev_note;
   logic [NUM_VOICES-1:0]           voice_active;
   logic [8*NUM_VOICES-1:0]         voice_notes;
   logic                            cfg_load;
   logic [$clog2(NUM_VOICES)-1:0]   cfg_voice;
   logic [7:0]                      cfg_note;
   logic                            cfg_enable;
   logic [7:0]                      steal_count;

   modport slave (
      input  ev_valid, ev_on, ev_note,
      output ev_ready, voice_active, voice_notes,
             cfg_load, cfg_voice, cfg_note, cfg_enable, steal_count
   );

   modport master (
      output ev_valid, ev_on, ev_note,
      input  ev_ready, voice_active, voice_notes,
             cfg_load, cfg_voice, cfg_note, cfg_enable, steal_count
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES accumulators with
// retrigger, free-voice and oldest-voice-steal policies, one event per IDLE/SCAN/COMMIT pass.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   voice_allocator_if.slave bus
);
   localparam int VIDX_W = $clog2(NUM_VOICES);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t                  state_q, state_d;
   logic                    on_q, on_d;
   logic [7:0]              note_q, note_d;
   logic [NUM_VOICES-1:0]   active_q, active_d;
   logic [7:0]              notes_q [NUM_VOICES];
   logic [7:0]              notes_d [NUM_VOICES];
   logic [AGE_W-1:0]        age_q [NUM_VOICES];
   logic [AGE_W-1:0]        age_d [NUM_VOICES];
   logic                    cfg_load_q, cfg_load_d;
   logic [VIDX_W-1:0]       cfg_voice_q, cfg_voice_d;
   logic [7:0]              cfg_note_q, cfg_note_d;
   logic                    cfg_enable_q, cfg_enable_d;
   logic [7:0]              steal_q, steal_d;

   logic                    accept;
   logic                    hit_found, free_found;
   logic [VIDX_W-1:0]       hit_idx, free_idx, old_idx;
   logic [AGE_W-1:0]        old_age;
   logic                    sel_valid, sel_steal;
   logic [VIDX_W-1:0]       sel_idx;

   function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
      return (&a) ? a : a + AGE_W'(1);
   endfunction

   function automatic logic [7:0] cnt_inc(input logic [7:0] c);
      return (&c) ? c : c + 8'd1;
   endfunction

   assign accept = bus.ev_valid && bus.ev_ready;

   // Voice search runs on the captured event; strict '>' keeps age ties on the lowest index.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      old_idx    = '0;
      old_age    = age_q[0];
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (active_q[i] && notes_q[i] == note_q && !hit_found) begin
            hit_found = 1'b1;
            hit_idx   = VIDX_W'(i);
         end
         if (!active_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = VIDX_W'(i);
         end
         if (age_q[i] > old_age) begin
            old_age = age_q[i];
            old_idx = VIDX_W'(i);
         end
      end

      sel_valid = 1'b0;
      sel_steal = 1'b0;
      sel_idx   = hit_idx;
      if (!note_q[7]) begin
         if (on_q) begin
            sel_valid = 1'b1;
            if (!hit_found && free_found) begin
               sel_idx = free_idx;
            end else if (!hit_found) begin
               sel_idx   = old_idx;
               sel_steal = 1'b1;
            end
         end else begin
            sel_valid = hit_found;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      on_d         = on_q;
      note_d       = note_q;
      active_d     = active_q;
      notes_d      = notes_q;
      age_d        = age_q;
      cfg_load_d   = 1'b0;
      cfg_voice_d  = cfg_voice_q;
      cfg_note_d   = cfg_note_q;
      cfg_enable_d = cfg_enable_q;
      steal_d      = steal_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SCAN;
               on_d    = bus.ev_on;
               note_d  = bus.ev_note;
            end
         end
         SCAN: begin
            state_d = COMMIT;
            if (sel_valid) begin
               cfg_load_d  = 1'b1;
               cfg_voice_d = sel_idx;
               if (on_q) begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (VIDX_W'(i) == sel_idx) begin
                        active_d[i] = 1'b1;
                        notes_d[i]  = note_q;
                        age_d[i]    = '0;
                     end else if (active_q[i]) begin
                        age_d[i] = age_inc(age_q[i]);
                     end
                  end
                  cfg_enable_d = 1'b1;
                  cfg_note_d   = note_q;
                  if (sel_steal) steal_d = cnt_inc(steal_q);
               end else begin
                  active_d[sel_idx] = 1'b0;
                  notes_d[sel_idx]  = '0;
                  age_d[sel_idx]    = '0;
                  cfg_enable_d      = 1'b0;
                  cfg_note_d        = '0;
               end
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         on_q         <= 1'b0;
         note_q       <= '0;
         active_q     <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            notes_q[i] <= '0;
            age_q[i]   <= '0;
         end
         cfg_load_q   <= 1'b0;
         cfg_voice_q  <= '0;
         cfg_note_q   <= '0;
         cfg_enable_q <= 1'b0;
         steal_q      <= '0;
      end else begin
         state_q      <= state_d;
         on_q         <= on_d;
         note_q       <= note_d;
         active_q     <= active_d;
         notes_q      <= notes_d;
         age_q        <= age_d;
         cfg_load_q   <= cfg_load_d;
         cfg_voice_q  <= cfg_voice_d;
         cfg_note_q   <= cfg_note_d;
         cfg_enable_q <= cfg_enable_d;
         steal_q      <= steal_d;
      end
   end

   assign bus.ev_ready     = (state_q == IDLE) && !reset;
   assign bus.voice_active = active_q;
   assign bus.cfg_load     = cfg_load_q;
   assign bus.cfg_voice    = cfg_voice_q;
   assign bus.cfg_note     = cfg_note_q;
   assign bus.cfg_enable   = cfg_enable_q;
   assign bus.steal_count  = steal_q;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_notes
      assign bus.voice_notes[8*g +: 8] = notes_q[g];
   end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: hand-computed allocation, steal, discard,
// throughput and reset-abort scenarios checked with immediate assertions.
module tb_voice_allocator;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   n_acc;
   int   n_loads;

   voice_allocator_if #(.NUM_VOICES(4)) bus ();

   voice_allocator #(.NUM_VOICES(4), .AGE_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One event through IDLE/SCAN/COMMIT; inputs are scrambled right after acceptance.
   task automatic send(input string tag, input logic on, input logic [7:0] note,
                       input logic exp_load, input logic [1:0] exp_voice,
                       input logic [7:0] exp_note, input logic exp_en);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.ev_ready), 32'd1);
      bus.ev_valid = 1'b1;
      bus.ev_on    = on;
      bus.ev_note  = note;
      @(posedge clk);
      #1;
      bus.ev_valid = 1'b0;
      bus.ev_on    = ~on;
      bus.ev_note  = note ^ 8'h15;
      chk({tag, "_scan_load"}, 32'(bus.cfg_load), 32'd0);
      chk({tag, "_scan_ready"}, 32'(bus.ev_ready), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_load"}, 32'(bus.cfg_load), 32'(exp_load));
      chk({tag, "_voice"}, 32'(bus.cfg_voice), 32'(exp_voice));
      chk({tag, "_note"}, 32'(bus.cfg_note), 32'(exp_note));
      chk({tag, "_en"}, 32'(bus.cfg_enable), 32'(exp_en));
      @(posedge clk);
      #1;
      chk({tag, "_idle_load"}, 32'(bus.cfg_load), 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.ev_valid = 1'b0;
      bus.ev_on    = 1'b0;
      bus.ev_note  = 8'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.ev_ready), 32'd0);
      chk("rst_active", 32'(bus.voice_active), 32'd0);
      chk("rst_notes", bus.voice_notes, 32'd0);
      chk("rst_load", 32'(bus.cfg_load), 32'd0);
      chk("rst_cfg", {bus.cfg_voice, bus.cfg_note, bus.cfg_enable}, 32'd0);
      chk("rst_steal", 32'(bus.steal_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(bus.ev_ready), 32'd1);

      // First note lands on voice 0; repeating it is a retrigger, not a steal.
      send("on60", 1'b1, 8'd60, 1'b1, 2'd0, 8'd60, 1'b1);
      chk("on60_active", 32'(bus.voice_active), 32'b0001);
      chk("on60_notes", bus.voice_notes, 32'h0000_003C);
      send("re60", 1'b1, 8'd60, 1'b1, 2'd0, 8'd60, 1'b1);
      chk("re60_active", 32'(bus.voice_active), 32'b0001);
      chk("re60_steal", 32'(bus.steal_count), 32'd0);

      send("on62", 1'b1, 8'd62, 1'b1, 2'd1, 8'd62, 1'b1);
      chk("on62_active", 32'(bus.voice_active), 32'b0011);
      chk("on62_notes", bus.voice_notes, 32'h0000_3E3C);
      send("off62", 1'b0, 8'd62, 1'b1, 2'd1, 8'd0, 1'b0);
      chk("off62_active", 32'(bus.voice_active), 32'b0001);
      chk("off62_notes", bus.voice_notes, 32'h0000_003C);
      // Unmatched and out-of-range events leave cfg_* holding the last commit.
      send("off62b", 1'b0, 8'd62, 1'b0, 2'd1, 8'd0, 1'b0);
      chk("off62b_active", 32'(bus.voice_active), 32'b0001);
      send("on200", 1'b1, 8'd200, 1'b0, 2'd1, 8'd0, 1'b0);
      send("on128", 1'b1, 8'd128, 1'b0, 2'd1, 8'd0, 1'b0);
      chk("on200_active", 32'(bus.voice_active), 32'b0001);
      chk("on200_notes", bus.voice_notes, 32'h0000_003C);

      // Fill the voices, then steal: v0 is oldest (age 4), then v1 (age 3).
      send("on62c", 1'b1, 8'd62, 1'b1, 2'd1, 8'd62, 1'b1);
      send("on64", 1'b1, 8'd64, 1'b1, 2'd2, 8'd64, 1'b1);
      send("on65", 1'b1, 8'd65, 1'b1, 2'd3, 8'd65, 1'b1);
      chk("full_active", 32'(bus.voice_active), 32'b1111);
      chk("full_steal", 32'(bus.steal_count), 32'd0);
      send("on67", 1'b1, 8'd67, 1'b1, 2'd0, 8'd67, 1'b1);
      chk("on67_steal", 32'(bus.steal_count), 32'd1);
      chk("on67_active", 32'(bus.voice_active), 32'b1111);
      chk("on67_notes", bus.voice_notes, 32'h4140_3E43);
      send("on69", 1'b1, 8'd69, 1'b1, 2'd1, 8'd69, 1'b1);
      chk("on69_steal", 32'(bus.steal_count), 32'd2);
      chk("on69_notes", bus.voice_notes, 32'h4140_4543);
      send("re64", 1'b1, 8'd64, 1'b1, 2'd2, 8'd64, 1'b1);
      chk("re64_steal", 32'(bus.steal_count), 32'd2);
      chk("re64_notes", bus.voice_notes, 32'h4140_4543);

      // Valid held high for 9 cycles with a discardable note: 3 acceptances, no loads.
      n_acc   = 0;
      n_loads = 0;
      @(negedge clk);
      bus.ev_valid = 1'b1;
      bus.ev_on    = 1'b1;
      bus.ev_note  = 8'd200;
      for (int c = 0; c < 9; c++) begin
         if (bus.ev_ready) n_acc++;
         @(posedge clk);
         #1;
         if (bus.cfg_load) n_loads++;
         @(negedge clk);
      end
      bus.ev_valid = 1'b0;
      chk("stream_accepts", 32'(n_acc), 32'd3);
      chk("stream_loads", 32'(n_loads), 32'd0);
      chk("stream_notes", bus.voice_notes, 32'h4140_4543);
      repeat (3) @(posedge clk);

      // Reset pulsed during the SCAN cycle of a note-on drops the event.
      @(negedge clk);
      chk("abort_ready", 32'(bus.ev_ready), 32'd1);
      bus.ev_valid = 1'b1;
      bus.ev_on    = 1'b1;
      bus.ev_note  = 8'd60;
      @(posedge clk);
      #1;
      bus.ev_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("abort_rst_ready", 32'(bus.ev_ready), 32'd0);
      chk("abort_rst_active", 32'(bus.voice_active), 32'd0);
      chk("abort_rst_steal", 32'(bus.steal_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_load1", 32'(bus.cfg_load), 32'd0);
      chk("abort_ready_after", 32'(bus.ev_ready), 32'd1);
      chk("abort_active", 32'(bus.voice_active), 32'd0);
      @(posedge clk);
      #1;
      chk("abort_load2", 32'(bus.cfg_load), 32'd0);

      send("on61", 1'b1, 8'd61, 1'b1, 2'd0, 8'd61, 1'b1);
      chk("on61_active", 32'(bus.voice_active), 32'b0001);
      chk("on61_notes", bus.voice_notes, 32'h0000_003D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
